// File: rtl/uart_tx_if.sv
// uart_tx_if: frame request and status bundle between a client and uart_tx.
// master = client issuing frames, slave = transmitter.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] length;
    logic       parity_type;
    logic       parity_en;
    logic       stop2;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start, tx_data, length,
        output parity_type, parity_en, stop2,
        input  tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  tx_start, tx_data, length,
        input  parity_type, parity_en, stop2,
        output tx_ready, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: configurable UART transmitter, OVERSAMPLE tx_clk cycles per bit.
// Define UART_TX_HOLD_EN to add a one-entry request holding register.
module uart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic     tx_clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     tx
);
    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [2:0]    bit_idx;
    logic [7:0]    dat;
    logic [3:0]    nbits;
    logic          par_bit;
    logic          par_en_q;
    logic          stop2_q;
    logic          busy;
    logic          done;

    logic          go;
    logic [7:0]    ld_data;
    logic [3:0]    ld_len;
    logic          ld_pt;
    logic          ld_pe;
    logic          ld_s2;
    logic [3:0]    ld_n;
    logic [7:0]    ld_mask;
    logic          ph_end;
    logic          bit_last;

`ifdef UART_TX_HOLD_EN
    logic       hold_valid;
    logic [7:0] hold_data;
    logic [3:0] hold_len;
    logic       hold_pt;
    logic       hold_pe;
    logic       hold_s2;
    logic       store;

    assign bus.tx_ready = !hold_valid;

    // The holder only fills mid-frame and always drains in DONE.
    always_comb begin
        go    = 1'b0;
        store = 1'b0;
        if (state == IDLE)
            go = bus.tx_start;
        else if (state == DONE)
            go = hold_valid || bus.tx_start;
        else
            store = bus.tx_start && !hold_valid;
    end

    assign ld_data = hold_valid ? hold_data : bus.tx_data;
    assign ld_len  = hold_valid ? hold_len  : bus.length;
    assign ld_pt   = hold_valid ? hold_pt   : bus.parity_type;
    assign ld_pe   = hold_valid ? hold_pe   : bus.parity_en;
    assign ld_s2   = hold_valid ? hold_s2   : bus.stop2;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_len   <= '0;
            hold_pt    <= 1'b0;
            hold_pe    <= 1'b0;
            hold_s2    <= 1'b0;
        end else if (store) begin
            hold_valid <= 1'b1;
            hold_data  <= bus.tx_data;
            hold_len   <= bus.length;
            hold_pt    <= bus.parity_type;
            hold_pe    <= bus.parity_en;
            hold_s2    <= bus.stop2;
        end else if (go && hold_valid) begin
            hold_valid <= 1'b0;
        end
    end
`else
    assign bus.tx_ready = (state == IDLE);
    assign go      = (state == IDLE) && bus.tx_start;
    assign ld_data = bus.tx_data;
    assign ld_len  = bus.length;
    assign ld_pt   = bus.parity_type;
    assign ld_pe   = bus.parity_en;
    assign ld_s2   = bus.stop2;
`endif

    // Out-of-range lengths fall back to a full byte.
    assign ld_n = (ld_len >= 4'd5 && ld_len <= 4'd8) ? ld_len : 4'd8;
    assign ld_mask  = 8'hFF >> (4'd8 - ld_n);
    assign ph_end   = (phase == PH_LAST);
    assign bit_last = ({1'b0, bit_idx} == (nbits - 4'd1));

    assign bus.tx_busy = busy;
    assign bus.tx_done = done;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            bit_idx  <= '0;
            dat      <= '0;
            nbits    <= 4'd8;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state   <= IDLE;
                    phase   <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    if (go) begin
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        dat      <= ld_data & ld_mask;
                        nbits    <= ld_n;
                        par_bit  <= (^(ld_data & ld_mask)) ^ ~ld_pt;
                        par_en_q <= ld_pe;
                        stop2_q  <= ld_s2;
                    end
                end
                default: begin
                    phase <= ph_end ? '0 : phase + PW'(1);
                    if (ph_end) begin
                        unique case (state)
                            START: begin
                                state   <= DATA;
                                bit_idx <= '0;
                                tx      <= dat[0];
                            end
                            DATA: begin
                                if (!bit_last) begin
                                    bit_idx <= bit_idx + 3'd1;
                                    tx      <= dat[bit_idx + 3'd1];
                                end else if (par_en_q) begin
                                    state <= PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= STOP1;
                                    tx    <= 1'b1;
                                end
                            end
                            PARITY: begin
                                state <= STOP1;
                                tx    <= 1'b1;
                            end
                            STOP1: begin
                                if (stop2_q) begin
                                    state <= STOP2;
                                end else begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end
                            STOP2: begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table, corner sequences and random loopback for uart_tx.
// Line decoding uses a behavioural receiver written from the frame format.
module tb_uart_tx;
    localparam int OS = 16;

    logic tx_clk = 1'b0;
    logic rst_n;
    logic tx;
    int   errors = 0;
    int   checks = 0;

    uart_tx_if bus ();

    uart_tx #(.OVERSAMPLE(OS)) dut (
        .tx_clk (tx_clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .tx     (tx)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  len;
        bit          pt;
        bit          pe;
        bit          s2;
        logic [11:0] bits;
        int          nb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic start_req(input logic [7:0] d, input logic [3:0] l,
                             input bit pt, input bit pe, input bit s2,
                             input string nm);
        int w;
        w = 0;
        while (bus.tx_ready !== 1'b1 && w < 400) begin
            @(negedge tx_clk);
            w++;
        end
        chk({nm, " ready"}, 32'(bus.tx_ready), 32'd1);
        bus.tx_data     = d;
        bus.length      = l;
        bus.parity_type = pt;
        bus.parity_en   = pe;
        bus.stop2       = s2;
        bus.tx_start    = 1'b1;
        @(negedge tx_clk);
        bus.tx_start    = 1'b0;
        bus.tx_data     = 8'($urandom);
        bus.length      = 4'($urandom);
        bus.parity_type = 1'($urandom);
        bus.parity_en   = 1'($urandom);
        bus.stop2       = 1'($urandom);
        chk({nm, " busy1"}, 32'(bus.tx_busy), 32'd1);
`ifdef UART_TX_HOLD_EN
        chk({nm, " rdy_mid"}, 32'(bus.tx_ready), 32'd1);
`else
        chk({nm, " rdy_mid"}, 32'(bus.tx_ready), 32'd0);
`endif
    endtask

    // Entered on the negedge of the first start-bit cycle (minus skip).
    task automatic expect_frame(input logic [11:0] bits, input int nb,
                                input int skip, input string nm);
        int   bad;
        int   bbad;
        logic e;
        bbad = 0;
        for (int k = 0; k < nb; k++) begin
            e   = bits[nb-1-k];
            bad = 0;
            for (int j = (k == 0) ? skip : 0; j < OS; j++) begin
                if (tx !== e) bad++;
                if (bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) bbad++;
                @(negedge tx_clk);
            end
            chk($sformatf("%s bit%0d", nm, k), 32'(bad), 32'd0);
        end
        chk({nm, " busy_in"}, 32'(bbad), 32'd0);
        chk({nm, " done"}, 32'(bus.tx_done), 32'd1);
        chk({nm, " done_tx"}, 32'(tx), 32'd1);
        chk({nm, " done_busy"}, 32'(bus.tx_busy), 32'd0);
    endtask

    task automatic rx_frame(input logic [3:0] len, input bit pe,
                            input bit pt, input bit s2,
                            output logic [7:0] rb, output bit err);
        int n;
        int w;
        n   = (len >= 5 && len <= 8) ? int'(len) : 8;
        rb  = '0;
        err = 1'b0;
        w   = 0;
        while (tx !== 1'b0 && w < 4) begin
            @(negedge tx_clk);
            w++;
        end
        repeat (OS / 2) @(negedge tx_clk);
        if (tx !== 1'b0) err = 1'b1;
        for (int i = 0; i < n; i++) begin
            repeat (OS) @(negedge tx_clk);
            rb[i] = tx;
        end
        if (pe) begin
            repeat (OS) @(negedge tx_clk);
            if (((^rb) ^ tx) !== !pt) err = 1'b1;
        end
        repeat (OS) @(negedge tx_clk);
        if (tx !== 1'b1) err = 1'b1;
        if (s2) begin
            repeat (OS) @(negedge tx_clk);
            if (tx !== 1'b1) err = 1'b1;
        end
    endtask

    task automatic run_vec(input int i, input string nm);
        start_req(vecs[i].data, vecs[i].len, vecs[i].pt, vecs[i].pe,
                  vecs[i].s2, nm);
        expect_frame(vecs[i].bits, vecs[i].nb, 0, nm);
        @(negedge tx_clk);
        chk({nm, " post_done"}, 32'(bus.tx_done), 32'd0);
        chk({nm, " post_rdy"}, 32'(bus.tx_ready), 32'd1);
        chk({nm, " post_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] rb;
        logic [7:0] mask;
        logic [3:0] l;
        bit         pe;
        bit         pt;
        bit         s2;
        bit         err;
        int         n;
        int         k;

        // First listed bit is the start bit, then data LSB first.
        vecs[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 12'b00_0101001011, 10};
        vecs[1] = '{8'h07, 4'd5,  1'b1, 1'b1, 1'b1, 12'b000_011100111, 9};
        vecs[2] = '{8'h07, 4'd5,  1'b0, 1'b1, 1'b1, 12'b000_011100011, 9};
        vecs[3] = '{8'h07, 4'd12, 1'b0, 1'b0, 1'b0, 12'b00_0111000001, 10};
        vecs[4] = '{8'hE0, 4'd5,  1'b1, 1'b1, 1'b0, 12'b0000_00000001, 8};
        vecs[5] = '{8'h3C, 4'd6,  1'b0, 1'b1, 1'b1, 12'b00_0001111111, 10};

        rst_n           = 1'b0;
        bus.tx_start    = 1'b0;
        bus.tx_data     = '0;
        bus.length      = 4'd8;
        bus.parity_type = 1'b0;
        bus.parity_en   = 1'b0;
        bus.stop2       = 1'b0;
        repeat (3) @(negedge tx_clk);
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst ready", 32'(bus.tx_ready), 32'd1);
        chk("rst busy", 32'(bus.tx_busy), 32'd0);
        chk("rst done", 32'(bus.tx_done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_vec(i, $sformatf("vec%0d", i));

        // Reset in the middle of data bit 3.
        start_req(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, "mid");
        repeat (4 * OS + 4) @(negedge tx_clk);
        chk("mid pre_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst_tx", 32'(tx), 32'd1);
        chk("mid rst_busy", 32'(bus.tx_busy), 32'd0);
        chk("mid rst_rdy", 32'(bus.tx_ready), 32'd1);
        chk("mid rst_done", 32'(bus.tx_done), 32'd0);
        repeat (2) @(negedge tx_clk);
        chk("mid hold_done", 32'(bus.tx_done), 32'd0);
        rst_n = 1'b1;
        run_vec(0, "mid_after");

        // tx_start held high across two back-to-back frames.
        bus.tx_data     = 8'h55;
        bus.length      = 4'd8;
        bus.parity_type = 1'b0;
        bus.parity_en   = 1'b0;
        bus.stop2       = 1'b0;
        bus.tx_start    = 1'b1;
        @(negedge tx_clk);
        bus.tx_data = 8'hAA;
`ifdef UART_TX_HOLD_EN
        @(negedge tx_clk);
        chk("b2b held_rdy", 32'(bus.tx_ready), 32'd0);
        bus.tx_start = 1'b0;
        expect_frame(12'b00_0101010101, 10, 1, "b2b1");
        @(negedge tx_clk);
`else
        expect_frame(12'b00_0101010101, 10, 0, "b2b1");
        @(negedge tx_clk);
        chk("b2b idle_tx", 32'(tx), 32'd1);
        chk("b2b idle_rdy", 32'(bus.tx_ready), 32'd1);
        @(negedge tx_clk);
        bus.tx_start = 1'b0;
`endif
        expect_frame(12'b00_0010101011, 10, 0, "b2b2");
        @(negedge tx_clk);
        chk("b2b post_done", 32'(bus.tx_done), 32'd0);

        for (int i = 0; i < 100; i++) begin
            d  = 8'($urandom);
            l  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(5, 8));
            pe = 1'($urandom);
            pt = 1'($urandom);
            s2 = 1'($urandom);
            n    = (l >= 5 && l <= 8) ? int'(l) : 8;
            mask = 8'((1 << n) - 1);
            start_req(d, l, pt, pe, s2, $sformatf("rnd%0d", i));
            rx_frame(l, pe, pt, s2, rb, err);
            chk($sformatf("rnd%0d data", i), 32'(rb), 32'(d & mask));
            chk($sformatf("rnd%0d err", i), 32'(err), 32'd0);
            k = 0;
            while (bus.tx_done !== 1'b1 && k < 3 * OS) begin
                @(negedge tx_clk);
                k++;
            end
            chk($sformatf("rnd%0d done", i), 32'(bus.tx_done), 32'd1);
            @(negedge tx_clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning tx_clk cycles per serial bit.
REQ-002 SHALL have port tx_clk  input  1  clock at OVERSAMPLE x baud rate; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port tx_start  input  1  request to send tx_data; sampled each tx_clk edge.
REQ-005 SHALL have port tx_data  input  8  payload, LSB transmitted first.
REQ-006 SHALL have port length  input  4  data bits per frame, legal 5..8.
REQ-007 SHALL have port parity_type  input  1  1 = even parity, 0 = odd parity.
REQ-008 SHALL have port parity_en  input  1  1 = insert parity bit after data.
REQ-009 SHALL have port stop2  input  1  1 = two stop bits, 0 = one.
REQ-010 SHALL have port tx  output  1  serial line, registered, idle high; feeds the receiver rx input.
REQ-011 SHALL have port tx_ready  output  1  high when a tx_start would be accepted this cycle.
REQ-012 SHALL have port tx_busy  output  1  high from the cycle after acceptance until frame end.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
REQ-015 SHALL accept a request when tx_start=1 and tx_ready=1, latching tx_data, length, parity_type, parity_en and stop2; later input changes SHALL NOT affect the frame in flight.
REQ-016 SHALL enter START on the edge after acceptance, with tx=0 from that edge (1-cycle latency).
REQ-017 SHALL hold each bit (START, each DATA bit, PARITY, STOP1, STOP2) on tx for exactly OVERSAMPLE cycles, using a bit-phase counter 0..OVERSAMPLE-1 that advances the state on reaching OVERSAMPLE-1.
REQ-018 SHALL send data bits 0..N-1 in DATA, where N = length for 5..8 and N = 8 for any other value.
REQ-019 SHALL, in PARITY, send the XOR of the N data bits when parity_type=1, or its inverse when parity_type=0; bits above N-1 SHALL be excluded.
REQ-020 SHALL skip PARITY when parity_en=0 and skip STOP2 when stop2=0.
REQ-021 SHALL drive tx=1 in STOP1, STOP2, DONE and IDLE.
REQ-022 SHALL spend exactly one cycle in DONE, asserting tx_done, then return to IDLE.
REQ-023 SHALL drive tx_ready = (state==IDLE) when UART_TX_HOLD_EN is undefined, so back-to-back frames have at least one idle-high cycle (DONE) between them.
REQ-024 SHALL ignore tx_start while tx_ready=0, with no side effects.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-frame, immediately force state IDLE, tx=1, tx_busy=0, tx_done=0, counters 0, and clear any held request.
REQ-026 SHALL drive tx_ready=1 while rst_n=0 and after release; the first acceptance is possible on the first edge with rst_n=1.

Configuration
REQ-027 SHALL, when UART_TX_HOLD_EN is defined, add a one-entry holding register: tx_ready = (holding register empty); a request accepted while busy is stored with its configuration and starts on the edge after DONE (START follows DONE directly).
REQ-028 SHALL, when UART_TX_HOLD_EN is defined and a request arrives in DONE with the holder empty, store it and start it as in REQ-027.
REQ-029 SHALL, without UART_TX_HOLD_EN, contain no holding register and behave per REQ-023.

Verification
REQ-030 SHALL verify: tx_data=8'hA5, length=8, no parity, stop2=0 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; tx_done pulses at cycle 161 after acceptance.
REQ-031 SHALL verify: tx_data=8'h07, length=5, parity_en=1, parity_type=1, stop2=1 -> data 1,1,1,0,0, parity 1, two stop bits; frame 9 bits = 144 cycles.
REQ-032 SHALL verify: same as REQ-031 with parity_type=0 -> parity bit 0; length=4'd12 -> 8 data bits sent.
REQ-033 SHALL verify: rst_n pulled low during bit 3 of DATA -> tx=1 immediately, tx_busy=0, no tx_done; next request sends a clean frame.
REQ-034 SHALL verify: tx_start held high continuously, 8'h55 then 8'hAA -> without UART_TX_HOLD_EN, exactly one idle-high cycle between frames; with it, STOP1 of frame 1 followed by DONE then START of frame 2, both frames intact.
REQ-035 SHALL verify: loopback tx -> uart_rx rx with matching configuration, 100 random bytes and settings -> rx_out equals tx_data masked to N bits, rx_err=0.
